// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and sizing constants for the register-file write arbiter
package regfile_pkg;
  typedef enum logic [1:0] {RESET, CLEAR, RUN} state_t;
  localparam int REG_ZERO = 0;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer side wins ties and flips after every grant
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid_a,
  input  logic valid_b,
  output logic ready_a,
  output logic ready_b
);
  logic ptr_q, ptr_d;
  always_comb begin
    ready_a = en && valid_a && (!valid_b || !ptr_q);
    ready_b = en && valid_b && (!valid_a || ptr_q);
    ptr_d = (ready_a || ready_b) ? !ptr_q : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the register file write port; zeroes the file after reset,
// then shares the port between two valid/ready requesters with round-robin priority.
module regfile_write_arbiter #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              ReqValidA,
  input  logic [ADDR_W-1:0] ReqAddrA,
  input  logic [DATA_W-1:0] ReqDataA,
  output logic              ReqReadyA,
  input  logic              ReqValidB,
  input  logic [ADDR_W-1:0] ReqAddrB,
  input  logic [DATA_W-1:0] ReqDataB,
  output logic              ReqReadyB,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic              InitDone
);
  import regfile_pkg::*;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(REG_ZERO);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic wen_q, wen_d, done_q, done_d;
  rr_arb2 u_arb (
    .clk(Clk),
    .rst_n(Rst_n),
    .en(state_q == RUN),
    .valid_a(ReqValidA),
    .valid_b(ReqValidB),
    .ready_a(ReqReadyA),
    .ready_b(ReqReadyB)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d = 1'b0;
    done_d = done_q;
    case (state_q)
      RESET: begin
        if (CLEAR_ON_RESET) begin
          state_d = CLEAR;
          wen_d = 1'b1;
          waddr_d = cnt_q;
          wdata_d = '0;
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = RUN;
          done_d = 1'b1;
        end
      end
      CLEAR: begin
        if (waddr_q == LAST_REG) begin
          state_d = RUN;
          done_d = 1'b1;
        end else begin
          wen_d = 1'b1;
          waddr_d = cnt_q;
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (ReqReadyA || ReqReadyB) begin
          waddr_d = ReqReadyA ? ReqAddrA : ReqAddrB;
          wdata_d = ReqReadyA ? ReqDataA : ReqDataB;
          wen_d = waddr_d != ZERO_REG;
        end
      end
      default: state_d = RESET;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= RESET;
      cnt_q <= ADDR_W'(1);
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q <= wen_d;
      done_q <= done_d;
    end
  end
  assign WriteRegister = waddr_q;
  assign WriteData = wdata_q;
  assign RegWrite = wen_q;
  assign InitDone = done_q;
endmodule
